ram16x16_master: RTL and testbench
==================================

# ram16x16_master

Request-driven initiator for the 16x16 synchronous RAM port (cs / w_en / op_en / addr / data, registered read data). It turns single or burst read/write requests on a valid/ready interface into correctly sequenced RAM strobes and returns read data with a response strobe. It also provides a clear sequence that zeroes all 16 words, because the RAM's own reset does not clear its array. It sits between a datapath/CPU-side requester and one RAM16x16 instance.

## Interface
- DATA_W, 16, data width; must match RAM word width
- ADDR_W, 4, address width; depth = 2**ADDR_W = 16
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request (IDLE only)
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  start address
- req_len  in  ADDR_W  beats minus one (0 → 1 beat, 15 → 16 beats)
- wd_valid  in  1  write-data beat present
- wd_ready  out  1  write beat accepted this cycle
- wd_data  in  DATA_W  write-data beat
- rsp_valid  out  1  read data valid this cycle (no backpressure)
- rsp_last  out  1  with rsp_valid: final beat of burst
- rsp_data  out  DATA_W  read data
- clr_start  in  1  pulse: zero the whole RAM
- clr_done  out  1  one-cycle pulse: clear complete
- busy  out  1  state != IDLE or response in flight
- ram_cs, ram_w_en, ram_op_en  out  1 each  RAM strobes
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  to RAM data_in
- ram_rdata  in  DATA_W  from RAM data_out

## Operation
- States: IDLE, WRITE, READ, DRAIN, CLEAR.
- IDLE: req_ready=1, all RAM strobes 0. clr_start takes priority over req_valid in the same cycle. clr_start → CLEAR with addr=0. Otherwise req_valid → WRITE or READ. On entry, latch cur_addr=req_addr and beats_left=req_len.
- WRITE: wd_ready=1. Each cycle with wd_valid, drive ram_cs=1, ram_w_en=1, ram_op_en=0, ram_addr=cur_addr, ram_wdata=wd_data. These are combinational from state and wd_data.
  - On that edge, cur_addr increments mod 16.
  - When beats_left==0 on an accepted beat, go to IDLE. Otherwise decrement beats_left.
  - With wd_valid=0, all strobes are 0 and the controller waits with no timeout.
- READ: every cycle drive ram_cs=1, ram_op_en=1, ram_w_en=0, ram_addr=cur_addr. Increment cur_addr mod 16 and decrement beats_left. After the beats_left==0 strobe, go to DRAIN.
- DRAIN: one cycle with strobes 0, then IDLE.
- Response path:
  - rsp_valid = registered copy of the read strobe.
  - rsp_last = registered copy of (read strobe && beats_left==0).
  - rsp_data = ram_rdata (pass-through).
- CLEAR: 16 consecutive write strobes with ram_wdata=0 at addresses 0..15. After address 15, pulse clr_done (registered, one cycle) and go to IDLE.
- Invariant: ram_w_en and ram_op_en are never both 1. Both are 0 whenever ram_cs=0.
- Address wrap: a burst starting at 14 with len 3 accesses 14, 15, 0, 1.

## Timing
- Reset (async assert, sync to clk on release):
  - state=IDLE, req_ready=1.
  - wd_ready, rsp_valid, rsp_last, clr_done, busy, ram_cs, ram_w_en, ram_op_en = 0.
  - ram_addr=0, ram_wdata=0, rsp_data follows ram_rdata.
- Request accept edge = E0.
- Read, N beats:
  - Strobes occupy cycles E0..E0+N−1.
  - Beat k data is on rsp_data with rsp_valid during the cycle after its strobe. First rsp_valid is in the cycle after edge E0+1. Latency is 2 edges from accept.
  - req_ready returns after DRAIN: N+1 cycles after E0.
- Write: each beat is committed at the edge where wd_valid && wd_ready. A zero-stall N-beat burst returns to IDLE N edges after E0.
- Clear: 16 cycles of strobes. clr_done is high during the cycle following the last strobe. busy stays 1 throughout.
- Reset mid-burst: abort immediately.
  - Strobes drop to 0 asynchronously and no rsp_valid is generated.
  - Partially written RAM contents are unspecified. Software must re-clear.
- Requests presented while not IDLE are ignored (req_ready=0). clr_start outside IDLE is ignored.

## Test plan
- Reset then single write: addr 3, data 0xA5A5, len 0 → one cycle with ram_cs=1, ram_w_en=1, ram_addr=3, ram_wdata=0xA5A5; back to IDLE after 1 edge.
- Single read of addr 3 after that write → rsp_valid 2 edges after accept, rsp_data=0xA5A5, rsp_last=1, req_ready high again after 2 cycles.
- Wrapping burst: write len 3 from addr 14 with data 0x1111..0x4444, wd_valid deasserted for 2 cycles mid-burst. Then read len 3 from addr 14 → addresses 14, 15, 0, 1; rsp_data 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles; rsp_last on the 4th beat only.
- clr_start and req_valid asserted together in IDLE → CLEAR wins: 16 zero writes to addresses 0..15, then clr_done pulse. A full 16-beat read from 0 then returns all 0x0000.
- reset_n asserted during cycle 5 of a 16-beat read → ram_cs and rsp_valid at 0 immediately; after release, state IDLE and req_ready=1.
- Checker over all tests: ram_w_en && ram_op_en never true; no strobe while ram_cs=0; rsp_valid count equals requested beats.

Source files
------------

// File: rtl/ram16x16_master_if.sv
// Bundle between a requester and the 16x16 RAM initiator.
// Carries request, write-data, response, clear and RAM strobe signals.
interface ram16x16_master_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_len;

  logic              wd_valid;
  logic              wd_ready;
  logic [DATA_W-1:0] wd_data;

  logic              rsp_valid;
  logic              rsp_last;
  logic [DATA_W-1:0] rsp_data;

  logic              clr_start;
  logic              clr_done;
  logic              busy;

  logic              ram_cs;
  logic              ram_w_en;
  logic              ram_op_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_len,
    input  wd_valid, wd_data,
    input  clr_start, ram_rdata,
    output req_ready, wd_ready,
    output rsp_valid, rsp_last, rsp_data,
    output clr_done, busy,
    output ram_cs, ram_w_en, ram_op_en,
    output ram_addr, ram_wdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_len,
    output wd_valid, wd_data,
    output clr_start, ram_rdata,
    input  req_ready, wd_ready,
    input  rsp_valid, rsp_last, rsp_data,
    input  clr_done, busy,
    input  ram_cs, ram_w_en, ram_op_en,
    input  ram_addr, ram_wdata
  );
endinterface

// File: rtl/ram16x16_master.sv
// Burst read/write and clear sequencer for a 16x16 synchronous RAM.
// Ports: clk, reset_n (async low), bus (master modport: req/wd/rsp/clr/ram).
module ram16x16_master #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input logic               clk,
  input logic               reset_n,
  ram16x16_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_CLEAR
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] beats_left_q, beats_left_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_last_q, rsp_last_d;
  logic              clr_done_q, clr_done_d;

  logic wr_beat;
  logic rd_beat;
  logic clr_beat;
  logic last_beat;

  // Strobes are combinational from state so that an async
  // reset of state_q drops them without waiting for an edge.
  assign wr_beat   = (state_q == S_WRITE) && bus.wd_valid;
  assign rd_beat   = (state_q == S_READ);
  assign clr_beat  = (state_q == S_CLEAR);
  assign last_beat = (beats_left_q == '0);

  assign bus.ram_cs    = wr_beat | rd_beat | clr_beat;
  assign bus.ram_w_en  = wr_beat | clr_beat;
  assign bus.ram_op_en = rd_beat;
  assign bus.ram_addr  = bus.ram_cs ? cur_addr_q : '0;
  assign bus.ram_wdata = wr_beat ? bus.wd_data
                                 : {DATA_W{1'b0}};

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.wd_ready  = (state_q == S_WRITE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_data  = bus.ram_rdata;
  assign bus.clr_done  = clr_done_q;
  assign bus.busy      = (state_q != S_IDLE)
                       | rsp_valid_q;

  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    clr_done_d   = 1'b0;
    rsp_valid_d  = rd_beat;
    rsp_last_d   = rd_beat && last_beat;

    unique case (state_q)
      S_IDLE: begin
        // Clear wins over a same-cycle request.
        if (bus.clr_start) begin
          state_d      = S_CLEAR;
          cur_addr_d   = '0;
          beats_left_d = ADDR_MAX;
        end else if (bus.req_valid) begin
          state_d      = bus.req_write ? S_WRITE
                                       : S_READ;
          cur_addr_d   = bus.req_addr;
          beats_left_d = bus.req_len;
        end
      end
      S_WRITE: begin
        if (bus.wd_valid) begin
          cur_addr_d = cur_addr_q + ADDR_ONE;
          if (last_beat) begin
            state_d = S_IDLE;
          end else begin
            beats_left_d = beats_left_q - ADDR_ONE;
          end
        end
      end
      S_READ: begin
        cur_addr_d = cur_addr_q + ADDR_ONE;
        if (last_beat) begin
          state_d = S_DRAIN;
        end else begin
          beats_left_d = beats_left_q - ADDR_ONE;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        cur_addr_d = cur_addr_q + ADDR_ONE;
        if (cur_addr_q == ADDR_MAX) begin
          state_d    = S_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_last_q   <= 1'b0;
      clr_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_last_q   <= rsp_last_d;
      clr_done_q   <= clr_done_d;
    end
  end

endmodule

// File: tb/tb_ram16x16_master.sv
// Directed bench for ram16x16_master with a behavioural 16x16 RAM.
// Covers reset, single/burst/wrapping access, clear and mid-burst reset.
module tb_ram16x16_master;

  localparam int DW = 16;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  ram16x16_master_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  ram16x16_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  logic [DW-1:0] mem [16];

  always @(posedge clk) begin
    if (bus.ram_cs && bus.ram_w_en) mem[bus.ram_addr] <= bus.ram_wdata;
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus.ram_rdata <= '0;
    else if (bus.ram_cs && bus.ram_op_en) bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_chk  = 0;
  int n_pass = 0;
  int n_rsp  = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    check("we_oe_excl", 32'(bus.ram_w_en & bus.ram_op_en), 32'd0);
    check("strobe_no_cs",
          32'(~bus.ram_cs & (bus.ram_w_en | bus.ram_op_en)), 32'd0);
    if (bus.rsp_valid) n_rsp++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_read(input logic [3:0] a, input logic [3:0] len,
                          input logic [15:0] exp [16]);
    logic [3:0] ea;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    bus.req_len   = len;
    #1;
    check("rd_accept_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    for (int c = 0; c <= int'(len) + 1; c++) begin
      ea = a + 4'(c);
      if (c <= int'(len)) begin
        check("rd_strobes", 32'({bus.ram_cs, bus.ram_w_en, bus.ram_op_en}),
              32'b101);
        check("rd_addr", 32'(bus.ram_addr), 32'(ea));
      end else begin
        check("rd_drain_cs", 32'(bus.ram_cs), 32'd0);
      end
      if (c > 0) begin
        check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("rsp_data", 32'(bus.rsp_data), 32'(exp[c-1]));
        check("rsp_last", 32'(bus.rsp_last), 32'(c - 1 == int'(len)));
      end else begin
        check("rsp_valid_lat", 32'(bus.rsp_valid), 32'd0);
      end
      check("rd_busy_ready", 32'({bus.busy, bus.req_ready}), 32'b10);
      tick();
    end
    check("rd_ready_back", 32'(bus.req_ready), 32'd1);
    check("rd_rsp_done", 32'(bus.rsp_valid), 32'd0);
  endtask

  logic [15:0] exp_a [16];
  logic [15:0] wdat [4];
  logic [3:0]  wadr [4];
  bit          vpat [6];
  int          b;

  initial begin
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.wd_valid  = 1'b0;
    bus.wd_data   = '0;
    bus.clr_start = 1'b0;
    wdat = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    wadr = '{4'd14, 4'd15, 4'd0, 4'd1};
    vpat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    #12;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_flags", 32'({bus.wd_ready, bus.rsp_valid, bus.rsp_last,
                            bus.clr_done, bus.busy}), 32'd0);
    check("rst_strobes", 32'({bus.ram_cs, bus.ram_w_en, bus.ram_op_en}),
          32'd0);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_wdata", 32'(bus.ram_wdata), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // single write
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 4'd3;
    bus.req_len   = 4'd0;
    bus.wd_valid  = 1'b1;
    bus.wd_data   = 16'hA5A5;
    tick();
    bus.req_valid = 1'b0;
    check("wr1_strobes", 32'({bus.ram_cs, bus.ram_w_en, bus.ram_op_en}),
          32'b110);
    check("wr1_addr", 32'(bus.ram_addr), 32'd3);
    check("wr1_wdata", 32'(bus.ram_wdata), 32'hA5A5);
    check("wr1_wd_ready", 32'(bus.wd_ready), 32'd1);
    tick();
    bus.wd_valid = 1'b0;
    #1;
    check("wr1_idle", 32'({bus.req_ready, bus.ram_cs}), 32'b10);

    // single read
    exp_a    = '{default: 16'h0};
    exp_a[0] = 16'hA5A5;
    run_read(4'd3, 4'd0, exp_a);

    // wrapping write burst with a 2-cycle stall
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 4'd14;
    bus.req_len   = 4'd3;
    tick();
    bus.req_valid = 1'b0;
    b = 0;
    for (int c = 0; c < 6; c++) begin
      bus.wd_valid = vpat[c];
      bus.wd_data  = wdat[b];
      #1;
      check("wrb_busy_ready", 32'({bus.busy, bus.wd_ready, bus.req_ready}),
            32'b110);
      if (vpat[c]) begin
        check("wrb_strobes",
              32'({bus.ram_cs, bus.ram_w_en, bus.ram_op_en}), 32'b110);
        check("wrb_addr", 32'(bus.ram_addr), 32'(wadr[b]));
        check("wrb_wdata", 32'(bus.ram_wdata), 32'(wdat[b]));
        b++;
      end else begin
        check("wrb_stall_cs", 32'(bus.ram_cs), 32'd0);
      end
      tick();
    end
    bus.wd_valid = 1'b0;
    #1;
    check("wrb_idle", 32'(bus.req_ready), 32'd1);

    // wrapping read burst
    exp_a    = '{default: 16'h0};
    exp_a[0] = 16'h1111;
    exp_a[1] = 16'h2222;
    exp_a[2] = 16'h3333;
    exp_a[3] = 16'h4444;
    run_read(4'd14, 4'd3, exp_a);

    // clear beats a simultaneous request
    bus.clr_start = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 4'd5;
    bus.req_len   = 4'd0;
    tick();
    bus.clr_start = 1'b0;
    bus.req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("clr_strobes", 32'({bus.ram_cs, bus.ram_w_en, bus.ram_op_en}),
            32'b110);
      check("clr_addr", 32'(bus.ram_addr), 32'(i));
      check("clr_wdata", 32'(bus.ram_wdata), 32'd0);
      check("clr_busy_done", 32'({bus.busy, bus.clr_done}), 32'b10);
      tick();
    end
    check("clr_done_pulse", 32'({bus.clr_done, bus.req_ready}), 32'b11);
    tick();
    check("clr_done_low", 32'(bus.clr_done), 32'd0);

    exp_a = '{default: 16'h0};
    run_read(4'd0, 4'd15, exp_a);

    // reset in the 5th cycle of a 16-beat read
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 4'd0;
    bus.req_len   = 4'd15;
    tick();
    bus.req_valid = 1'b0;
    repeat (4) tick();
    check("abort_pre_cs", 32'(bus.ram_cs), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_cs", 32'(bus.ram_cs), 32'd0);
    check("abort_rsp", 32'(bus.rsp_valid), 32'd0);
    check("abort_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("post_rst_ready", 32'({bus.req_ready, bus.busy}), 32'b10);
    tick();
    check("post_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    tick();

    // 1 + 4 + 16 beats, plus 3 seen before the abort
    check("rsp_count", 32'(n_rsp), 32'd24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
